// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: idle pin levels, digit
// count, slot phase encodings and the anode one-cold helper.
// Optional feature macro used by this slice: SEG7_DIM_EN (PWM brightness).
package seg7_pkg;

  // Number of digits on the display.
  localparam int NDIG = 4;
  localparam int IDXW = $clog2(NDIG);

  // Active-low idle levels: all segments dark, all anodes released.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Slot phase encodings.
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  // One segment vector, {g,f,e,d,c,b,a}, active-low.
  typedef logic [6:0] seg_t;

  // Anode enable pattern with only the selected digit driven low.
  function automatic logic [NDIG-1:0] an_select(input logic [IDXW-1:0] idx);
    logic [NDIG-1:0] one_hot;
    one_hot   = '0;
    one_hot[idx] = 1'b1;
    an_select = ~one_hot;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot timer for the scan driver. cnt/idx name the slot position that the
// output registers load on the next clock edge, so the registered pins always
// line up with the position described here (cnt=0, idx=0 is the first pin
// cycle after reset). A small BLANK/SHOW phase FSM tracks the blanking gap.
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 200
) (
  input  logic            clk100_i,
  input  logic            rst_i,
  output logic            slot_start,
  output logic            in_blank,
  output logic [IDXW-1:0] idx
);

  localparam int CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          slot_end;

  assign slot_end   = (cnt == CNT_LAST);
  assign slot_start = (cnt == '0);

  // Cycle counter within a slot; the digit index advances on each wrap.
  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + IDXW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

      logic [0:0] state;

      // Phase FSM: every slot opens in BLANK, moves to SHOW after the last
      // blank cycle and returns to BLANK when the slot wraps.
      always_ff @(posedge clk100_i) begin
        if (rst_i) begin
          state <= ST_BLANK;
        end else if (slot_end) begin
          state <= ST_BLANK;
        end else if (cnt == BLANK_LAST) begin
          state <= ST_SHOW;
        end
      end

      assign in_blank = (state == ST_BLANK);
    end else begin : g_no_blank
      // No blanking gap: every position of every slot is SHOW.
      assign in_blank = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes four active-low segment vectors onto a common-anode
// display. A coherent snapshot of all four digits is taken at the start of
// each refresh frame, each digit slot starts with a blanking gap, and every
// pin is registered (no input-to-output combinational path).
// Optional feature: SEG7_DIM_EN adds dim_i and a 3-bit PWM that gates the
// anode during SHOW (drive while pwm <= dim_i).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 200
) (
  input  logic       clk100_i,
  input  logic       rst_i,
  input  logic [6:0] hex0_i,
  input  logic [6:0] hex1_i,
  input  logic [6:0] hex2_i,
  input  logic [6:0] hex3_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       frame_o
`ifdef SEG7_DIM_EN
  ,
  input  logic [2:0] dim_i
`endif
);

  logic            slot_start;
  logic            in_blank;
  logic [IDXW-1:0] idx;
  logic            frame_start;
  logic            drive_on;
  seg_t            cur_seg;
  seg_t            snap [NDIG];
  logic [3:0]      an_next;
  seg_t            seg_next;

  seg7_slot_timer #(
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk100_i   (clk100_i),
    .rst_i      (rst_i),
    .slot_start (slot_start),
    .in_blank   (in_blank),
    .idx        (idx)
  );

  // The frame opens at the first position of digit 0.
  assign frame_start = slot_start && (idx == '0);

  // Frame snapshot: all four digits are captured together so a value
  // changing mid-frame can never tear across digits.
  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      for (int i = 0; i < NDIG; i++) begin
        snap[i] <= SEG_BLANK;
      end
    end else if (frame_start) begin
      snap[0] <= hex0_i;
      snap[1] <= hex1_i;
      snap[2] <= hex2_i;
      snap[3] <= hex3_i;
    end
  end

`ifdef SEG7_DIM_EN
  logic [2:0] pwm;

  // Brightness PWM: counts through SHOW positions and restarts in BLANK so
  // every SHOW phase begins at pwm=0.
  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      pwm <= '0;
    end else if (in_blank) begin
      pwm <= '0;
    end else begin
      pwm <= pwm + 3'd1;
    end
  end

  assign drive_on = !in_blank && (pwm <= dim_i);
`else
  assign drive_on = !in_blank;
`endif

  // Next pin values. On the frame's first position the snapshot register is
  // being loaded in the same edge, so digit 0 is taken straight from hex0_i;
  // this only matters when there is no blanking gap.
  always_comb begin
    cur_seg  = snap[idx];
    an_next  = AN_OFF;
    seg_next = SEG_BLANK;
    if (frame_start) begin
      cur_seg = hex0_i;
    end
    if (drive_on) begin
      an_next  = an_select(idx);
      seg_next = cur_seg;
    end
  end

  // Output registers.
  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      an_o    <= AN_OFF;
      seg_o   <= SEG_BLANK;
      frame_o <= 1'b0;
    end else begin
      an_o    <= an_next;
      seg_o   <= seg_next;
      frame_o <= frame_start;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: DIGIT_CYCLES=10 with BLANK_CYCLES=2
// (dut_a) and BLANK_CYCLES=0 (dut_b). Dimming checks compile in with
// SEG7_DIM_EN.
module tb_seg7_scan_driver;

  localparam int DC = 10;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [6:0] hex0, hex1, hex2, hex3;
  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       frame_a, frame_b;
  logic [2:0] dim = 3'd7;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] drv  [4];
  logic [6:0] msnap[4];

  seg7_scan_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(2)) dut_a (
    .clk100_i (clk),
    .rst_i    (rst),
    .hex0_i   (hex0),
    .hex1_i   (hex1),
    .hex2_i   (hex2),
    .hex3_i   (hex3),
    .an_o     (an_a),
    .seg_o    (seg_a),
    .frame_o  (frame_a)
`ifdef SEG7_DIM_EN
    ,
    .dim_i    (dim)
`endif
  );

  seg7_scan_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(0)) dut_b (
    .clk100_i (clk),
    .rst_i    (rst),
    .hex0_i   (hex0),
    .hex1_i   (hex1),
    .hex2_i   (hex2),
    .hex3_i   (hex3),
    .an_o     (an_b),
    .seg_o    (seg_b),
    .frame_o  (frame_b)
`ifdef SEG7_DIM_EN
    ,
    .dim_i    (3'd7)
`endif
  );

  // Safety net: the run is bounded by fixed loops, this only catches a stall.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1);
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_hex();
    hex0 = drv[0];
    hex1 = drv[1];
    hex2 = drv[2];
    hex3 = drv[3];
  endtask

  task automatic load_default_hex();
    drv[0] = 7'h30;
    drv[1] = 7'h24;
    drv[2] = 7'h79;
    drv[3] = 7'h40;
    drive_hex();
  endtask

  function automatic logic [3:0] an_for(input int slot);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << slot);
  endfunction

  // Reset held for three cycles: pins idle, no frame pulse.
  task automatic test_reset();
    rst = 1'b1;
    load_default_hex();
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (an_a !== 4'hF) begin
        n_err++;
        $display("FAIL reset_an cyc=%0d got=%h exp=%h", i, an_a, 4'hF);
      end
      n_vec++;
      if (seg_a !== 7'h7F) begin
        n_err++;
        $display("FAIL reset_seg cyc=%0d got=%h exp=%h", i, seg_a, 7'h7F);
      end
      n_vec++;
      if (frame_a !== 1'b0) begin
        n_err++;
        $display("FAIL reset_frame cyc=%0d got=%b exp=0", i, frame_a);
      end
    end
  endtask

  // Scan pattern across a frame and a half, with hex0 changed at cycle 15:
  // digit 0 keeps the old snapshot until the frame at cycle 40.
  task automatic test_scan_and_update();
    int pos, slot;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_frame;
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (c % 40 == 0) begin
        for (int k = 0; k < 4; k++) msnap[k] = drv[k];
      end
      pos       = c % DC;
      slot      = (c / DC) % 4;
      exp_frame = (c % 40 == 0);
      exp_an    = (pos < 2) ? 4'hF : an_for(slot);
      exp_seg   = (pos < 2) ? 7'h7F : msnap[slot];
      n_vec++;
      if (frame_a !== exp_frame) begin
        n_err++;
        $display("FAIL scan_frame cyc=%0d got=%b exp=%b", c, frame_a, exp_frame);
      end
      n_vec++;
      if (an_a !== exp_an) begin
        n_err++;
        $display("FAIL scan_an cyc=%0d got=%b exp=%b", c, an_a, exp_an);
      end
      n_vec++;
      if (seg_a !== exp_seg) begin
        n_err++;
        $display("FAIL scan_seg cyc=%0d got=%h exp=%h", c, seg_a, exp_seg);
      end
      if (c == 15) begin
        drv[0] = 7'h19;
        drive_hex();
      end
    end
    // Hand spot-checks at cycle 49 (digit 0 slot of frame 2, new value).
    n_vec++;
    if (seg_a !== 7'h19) begin
      n_err++;
      $display("FAIL update_seg got=%h exp=%h", seg_a, 7'h19);
    end
  endtask

  // Reset asserted while digit 2 is shown, then scan restart.
  task automatic test_mid_reset();
    rst = 1'b1;
    load_default_hex();
    step();
    rst = 1'b0;
    for (int c = 0; c <= 25; c++) step();
    n_vec++;
    if (an_a !== 4'b1011 || seg_a !== 7'h79) begin
      n_err++;
      $display("FAIL midrst_pre got an=%b seg=%h exp an=1011 seg=79", an_a, seg_a);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++;
      if (an_a !== 4'hF || seg_a !== 7'h7F || frame_a !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_hold cyc=%0d got an=%b seg=%h frame=%b exp an=1111 seg=7f frame=0",
                 i, an_a, seg_a, frame_a);
      end
    end
    rst = 1'b0;
    step();
    n_vec++;
    if (frame_a !== 1'b1 || an_a !== 4'hF || seg_a !== 7'h7F) begin
      n_err++;
      $display("FAIL midrst_restart got an=%b seg=%h frame=%b exp an=1111 seg=7f frame=1",
               an_a, seg_a, frame_a);
    end
    step();
    step();
    n_vec++;
    if (an_a !== 4'b1110 || seg_a !== 7'h30 || frame_a !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_digit0 got an=%b seg=%h frame=%b exp an=1110 seg=30 frame=0",
               an_a, seg_a, frame_a);
    end
  endtask

  // BLANK_CYCLES=0: every cycle shows, one anode low, stepping every slot.
  task automatic test_no_blank();
    int slot;
    logic [3:0] exp_an;
    logic       exp_frame;
    rst = 1'b1;
    load_default_hex();
    step();
    rst = 1'b0;
    for (int c = 0; c < 45; c++) begin
      step();
      slot      = (c / DC) % 4;
      exp_an    = an_for(slot);
      exp_frame = (c % 40 == 0);
      n_vec++;
      if (an_b !== exp_an) begin
        n_err++;
        $display("FAIL noblank_an cyc=%0d got=%b exp=%b", c, an_b, exp_an);
      end
      n_vec++;
      if (seg_b !== drv[slot]) begin
        n_err++;
        $display("FAIL noblank_seg cyc=%0d got=%h exp=%h", c, seg_b, drv[slot]);
      end
      n_vec++;
      if (frame_b !== exp_frame) begin
        n_err++;
        $display("FAIL noblank_frame cyc=%0d got=%b exp=%b", c, frame_b, exp_frame);
      end
      n_vec++;
      if ($countones(~an_b) != 1) begin
        n_err++;
        $display("FAIL noblank_onehot cyc=%0d got=%b exp=exactly one low", c, an_b);
      end
    end
  endtask

`ifdef SEG7_DIM_EN
  // dim_i=1: anode driven in the first two SHOW cycles of each slot only.
  task automatic test_dim();
    int pos, slot;
    logic       on;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    dim = 3'd1;
    rst = 1'b1;
    load_default_hex();
    step();
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      pos     = c % DC;
      slot    = (c / DC) % 4;
      on      = (pos == 2) || (pos == 3);
      exp_an  = on ? an_for(slot) : 4'hF;
      exp_seg = on ? drv[slot] : 7'h7F;
      n_vec++;
      if (an_a !== exp_an) begin
        n_err++;
        $display("FAIL dim_an cyc=%0d got=%b exp=%b", c, an_a, exp_an);
      end
      n_vec++;
      if (seg_a !== exp_seg) begin
        n_err++;
        $display("FAIL dim_seg cyc=%0d got=%h exp=%h", c, seg_a, exp_seg);
      end
    end
    dim = 3'd7;
  endtask
`endif

  // Sequencer and final report
  initial begin
    hex0 = 7'h7F;
    hex1 = 7'h7F;
    hex2 = 7'h7F;
    hex3 = 7'h7F;
    test_reset();
    test_scan_and_update();
    test_mid_reset();
    test_no_blank();
`ifdef SEG7_DIM_EN
    test_dim();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
